// File: rtl/mips16_pkg.sv
// Shared definitions for the 16-bit MIPS boot path.
// Contents:
//   INST_SIZE       - instruction word width
//   loader_state_e  - states of the instruction-memory loader
//   ERR_*           - loader error codes reported on err_code
//   loader_accepts  - 1 in every state that takes stream bytes
package mips16_pkg;

    localparam int INST_SIZE = 16;

    typedef enum logic [2:0] {
        HDR_HI  = 3'd0,
        HDR_LO  = 3'd1,
        DATA_HI = 3'd2,
        DATA_LO = 3'd3,
        CHECK   = 3'd4,
        DONE    = 3'd5,
        ERROR   = 3'd6
    } loader_state_e;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_CSUM    = 2'd1;
    localparam logic [1:0] ERR_LEN     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    // The terminal states park the stream; everything else consumes bytes.
    function automatic logic loader_accepts(loader_state_e s);
        return (s != DONE) && (s != ERROR);
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write bus of the loader.
// Signals:
//   in_valid, in_data  - byte offered by the upstream source
//   in_ready           - loader can accept a byte
//   imem_we            - one-cycle write strobe
//   imem_addr          - write address (ADDR_W bits)
//   imem_wdata         - instruction word
// Modports: master = stream source / memory side, slave = loader.
interface imem_loader_if #(
    parameter int ADDR_W = 13
);
    import mips16_pkg::*;

    logic                 in_valid;
    logic [7:0]           in_data;
    logic                 in_ready;
    logic                 imem_we;
    logic [ADDR_W-1:0]    imem_addr;
    logic [INST_SIZE-1:0] imem_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata
    );

endinterface

// File: rtl/idle_timer.sv
// Saturating idle counter with clear, enable and an expired flag.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   clr_i       - clear the count (wins over enable)
//   en_i        - count this cycle
//   expired_o   - count has reached LIMIT (never set when LIMIT is 0)
module idle_timer #(
    parameter int unsigned LIMIT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int unsigned CNT_W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

    logic [CNT_W-1:0] cnt_q;

    assign expired_o = (LIMIT != 0) && (cnt_q == CNT_W'(LIMIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && !expired_o) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: receives a framed byte stream (N hi/lo, N words hi/lo,
// XOR checksum) and writes the words into instruction memory from address 0.
// The core is held in reset until a full frame with a good checksum lands.
// Ports:
//   clk, rst   - clock, asynchronous active-low reset
//   start      - restart a load from DONE or ERROR
//   bus        - stream handshake and imem write bus (slave side)
//   cpu_hold   - 1 keeps the core in reset
//   load_done  - frame loaded and checksum good
//   load_err   - frame failed
//   err_code   - ERR_NONE / ERR_CSUM / ERR_LEN / ERR_TIMEOUT
module imem_loader
    import mips16_pkg::*;
#(
    parameter int          ADDR_W    = 13,
    parameter int          MAX_WORDS = 8192,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    imem_loader_if.slave      bus,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err,
    output logic [1:0]        err_code
);
    localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

    loader_state_e        state_q;
    logic [15:0]          n_q;
    logic [15:0]          idx_q;
    logic [7:0]           hi_q;
    logic [7:0]           acc_q;
    logic                 we_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [INST_SIZE-1:0] wdata_q;
    logic                 hold_q;
    logic                 done_q;
    logic                 err_q;
    logic [1:0]           code_q;

    logic                 accept;
    logic                 active;
    logic                 expired;
    logic                 tmo;
    logic [15:0]          n_d;

    assign bus.in_ready   = loader_accepts(state_q);
    assign accept         = bus.in_valid && bus.in_ready;
    // The timer only runs inside a frame, i.e. after the first header byte.
    assign active         = loader_accepts(state_q) && (state_q != HDR_HI);
    assign tmo            = expired && active;
    assign n_d            = {n_q[15:8], bus.in_data};

    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign cpu_hold       = hold_q;
    assign load_done      = done_q;
    assign load_err       = err_q;
    assign err_code       = code_q;

    idle_timer #(
        .LIMIT (TIMEOUT)
    ) u_idle_timer (
        .clk       (clk),
        .rst_n     (rst),
        .clr_i     (accept || !active),
        .en_i      (active),
        .expired_o (expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= HDR_HI;
            n_q     <= '0;
            idx_q   <= '0;
            hi_q    <= '0;
            acc_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            hold_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
        end else begin
            we_q <= 1'b0;
            // A timeout discards any byte accepted in the same cycle.
            if (tmo) begin
                state_q <= ERROR;
                err_q   <= 1'b1;
                code_q  <= ERR_TIMEOUT;
            end else begin
                case (state_q)
                    HDR_HI: if (accept) begin
                        n_q[15:8] <= bus.in_data;
                        acc_q     <= acc_q ^ bus.in_data;
                        state_q   <= HDR_LO;
                    end
                    HDR_LO: if (accept) begin
                        n_q[7:0] <= bus.in_data;
                        acc_q    <= acc_q ^ bus.in_data;
                        if ({1'b0, n_d} > MAX_N) begin
                            state_q <= ERROR;
                            err_q   <= 1'b1;
                            code_q  <= ERR_LEN;
                        end else if (n_d == 16'd0) begin
                            state_q <= CHECK;
                        end else begin
                            state_q <= DATA_HI;
                        end
                    end
                    DATA_HI: if (accept) begin
                        hi_q    <= bus.in_data;
                        acc_q   <= acc_q ^ bus.in_data;
                        state_q <= DATA_LO;
                    end
                    DATA_LO: if (accept) begin
                        we_q    <= 1'b1;
                        wdata_q <= {hi_q, bus.in_data};
                        addr_q  <= ADDR_W'(idx_q);
                        idx_q   <= idx_q + 16'd1;
                        acc_q   <= acc_q ^ bus.in_data;
                        state_q <= (idx_q == n_q - 16'd1) ? CHECK : DATA_HI;
                    end
                    CHECK: if (accept) begin
                        if (bus.in_data == acc_q) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            hold_q  <= 1'b0;
                        end else begin
                            state_q <= ERROR;
                            err_q   <= 1'b1;
                            code_q  <= ERR_CSUM;
                        end
                    end
                    DONE, ERROR: if (start) begin
                        state_q <= HDR_HI;
                        n_q     <= '0;
                        idx_q   <= '0;
                        acc_q   <= '0;
                        hold_q  <= 1'b1;
                        done_q  <= 1'b0;
                        err_q   <= 1'b0;
                        code_q  <= ERR_NONE;
                    end
                    default: state_q <= ERROR;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
    localparam int AW       = 13;
    localparam int MAXW     = 8192;
    localparam int TMO      = 16;

    typedef logic [7:0] bq_t [$];
    typedef struct packed {
        logic [AW-1:0] a;
        logic [15:0]   d;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       cpu_hold;
    logic       load_done;
    logic       load_err;
    logic [1:0] err_code;

    imem_loader_if #(.ADDR_W(AW)) bus ();

    imem_loader #(
        .ADDR_W    (AW),
        .MAX_WORDS (MAXW),
        .TIMEOUT   (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bus       (bus),
        .cpu_hold  (cpu_hold),
        .load_done (load_done),
        .load_err  (load_err),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    int          total  = 0;
    int          passed = 0;
    int          wr_cnt = 0;
    wr_t         exp_q[$];
    logic [15:0] tb_mem [0:MAXW-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // Frame-level model: decode the byte list directly into the list of
    // writes it must cause and the final status.
    task automatic model_frame(input bq_t fr, output logic ok, output logic [1:0] code,
                               output int nwr);
        int          n;
        logic [7:0]  acc;
        wr_t         w;
        exp_q.delete();
        n   = {fr[0], fr[1]};
        nwr = 0;
        if (n > MAXW) begin
            ok = 1'b0; code = 2'd2;
            return;
        end
        acc = fr[0] ^ fr[1];
        for (int i = 0; i < n; i++) begin
            w.a = AW'(i);
            w.d = {fr[2 + 2 * i], fr[3 + 2 * i]};
            acc = acc ^ fr[2 + 2 * i] ^ fr[3 + 2 * i];
            exp_q.push_back(w);
            nwr++;
        end
        ok   = (fr[2 + 2 * n] == acc);
        code = ok ? 2'd0 : 2'd1;
    endtask

    // Monitor: every write is compared against the model's expected list.
    always @(negedge clk) begin
        wr_t w;
        if (rst) begin
            check("cpu_hold_vs_done", 32'(cpu_hold), 32'(!load_done));
            check("in_ready_vs_status", 32'(bus.in_ready), 32'(!(load_done || load_err)));
            if (bus.imem_we) begin
                wr_cnt++;
                tb_mem[bus.imem_addr] = bus.imem_wdata;
                if (exp_q.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, want no write",
                             bus.imem_addr, bus.imem_wdata);
                end else begin
                    w = exp_q.pop_front();
                    check("wr_addr", 32'(bus.imem_addr), 32'(w.a));
                    check("wr_data", 32'(bus.imem_wdata), 32'(w.d));
                end
            end
        end
    end

    task automatic send_bytes(input bq_t fr, input int gap_max);
        int g;
        for (int i = 0; i < fr.size(); i++) begin
            if (!bus.in_ready) break;
            if (gap_max > 0) begin
                g = $urandom_range(0, gap_max);
                if (g > 0) begin
                    bus.in_valid = 1'b0;
                    repeat (g) @(posedge clk);
                    #1;
                end
            end
            bus.in_valid = 1'b1;
            bus.in_data  = fr[i];
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_status(input string name);
        int n = 0;
        while (!(load_done || load_err) && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!(load_done || load_err)) check({name, "_status_wait"}, 32'(n), 32'(0));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_frame(input string name, input bq_t fr, input int gap_max);
        logic       ok;
        logic [1:0] code;
        int         nwr;
        model_frame(fr, ok, code, nwr);
        wr_cnt = 0;
        send_bytes(fr, gap_max);
        wait_status(name);
        repeat (2) @(posedge clk);
        #1;
        check({name, "_load_done"}, 32'(load_done), 32'(ok));
        check({name, "_load_err"},  32'(load_err),  32'(!ok));
        check({name, "_err_code"},  32'(err_code),  32'(code));
        check({name, "_cpu_hold"},  32'(cpu_hold),  32'(!ok));
        check({name, "_wr_count"},  32'(wr_cnt),    32'(nwr));
        check({name, "_missing_wr"}, 32'(exp_q.size()), 32'(0));
    endtask

    initial begin
        bq_t        good, bad, lenf, zero, part;
        logic       m_ok;
        logic [1:0] m_code;
        int         m_nwr;
        int         idle;

        good = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        bad  = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h43};
        lenf = '{8'h20, 8'h01};
        zero = '{8'h00, 8'h00, 8'h00};
        part = '{8'h00, 8'h01, 8'h12};

        rst = 1'b0; start = 1'b0; bus.in_valid = 1'b0; bus.in_data = 8'h00;
        for (int i = 0; i < MAXW; i++) tb_mem[i] = 16'h0;

        // Pin the model with hand-computed values.
        model_frame(good, m_ok, m_code, m_nwr);
        check("model_good_ok", 32'(m_ok), 32'(1));
        check("model_good_nwr", 32'(m_nwr), 32'(2));
        check("model_good_w1", 32'(exp_q[1].d), 32'h0000ABCD);
        model_frame(bad, m_ok, m_code, m_nwr);
        check("model_bad_code", 32'(m_code), 32'(1));
        exp_q.delete();

        repeat (3) @(posedge clk);
        #1;
        check("rst_imem_we",    32'(bus.imem_we),    32'(0));
        check("rst_imem_addr",  32'(bus.imem_addr),  32'(0));
        check("rst_imem_wdata", 32'(bus.imem_wdata), 32'(0));
        check("rst_cpu_hold",   32'(cpu_hold),       32'(1));
        check("rst_load_done",  32'(load_done),      32'(0));
        check("rst_load_err",   32'(load_err),       32'(0));
        check("rst_err_code",   32'(err_code),       32'(0));
        check("rst_in_ready",   32'(bus.in_ready),   32'(1));
        rst = 1'b1;
        @(posedge clk);
        #1;

        run_frame("good", good, 0);
        check("good_mem0", 32'(tb_mem[0]), 32'h1234);
        check("good_mem1", 32'(tb_mem[1]), 32'hABCD);
        // DONE ignores stream bytes and holds outputs.
        bus.in_valid = 1'b1; bus.in_data = 8'h55;
        repeat (3) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("done_hold", 32'(load_done), 32'(1));
        check("done_no_extra_wr", 32'(wr_cnt), 32'(2));

        pulse_start();
        check("start_clears_done", 32'(load_done), 32'(0));
        check("start_sets_hold",   32'(cpu_hold),  32'(1));
        run_frame("bad_csum", bad, 0);
        check("bad_err_code_lit", 32'(err_code), 32'(1));

        pulse_start();
        run_frame("len", lenf, 0);
        check("len_err_code_lit", 32'(err_code), 32'(2));

        pulse_start();
        run_frame("zero", zero, 0);
        check("zero_done_lit", 32'(load_done), 32'(1));

        // Timeout: frame stalls inside the first data word.
        pulse_start();
        exp_q.delete();
        wr_cnt = 0;
        send_bytes(part, 0);
        idle = 0;
        while (!load_err && idle < 40) begin
            @(posedge clk);
            #1;
            idle++;
        end
        check("tmo_err",      32'(load_err), 32'(1));
        check("tmo_code",     32'(err_code), 32'(3));
        check("tmo_hold",     32'(cpu_hold), 32'(1));
        check("tmo_no_write", 32'(wr_cnt),   32'(0));
        check("tmo_not_early", 32'(idle >= TMO), 32'(1));
        check("tmo_not_late",  32'(idle <= TMO + 1), 32'(1));

        pulse_start();
        run_frame("after_tmo", good, 0);

        pulse_start();
        tb_mem[0] = 16'h0; tb_mem[1] = 16'h0;
        run_frame("gaps", good, 5);
        check("gaps_mem0", 32'(tb_mem[0]), 32'h1234);
        check("gaps_mem1", 32'(tb_mem[1]), 32'hABCD);

        // Reset while in DATA_LO of the second word.
        pulse_start();
        model_frame(good, m_ok, m_code, m_nwr);
        wr_cnt = 0;
        send_bytes('{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB}, 0);
        check("pre_rst_wdata", 32'(bus.imem_wdata), 32'h1234);
        #2;
        rst = 1'b0;
        #1;
        exp_q.delete();
        check("mid_rst_imem_we",    32'(bus.imem_we),    32'(0));
        check("mid_rst_imem_addr",  32'(bus.imem_addr),  32'(0));
        check("mid_rst_imem_wdata", 32'(bus.imem_wdata), 32'(0));
        check("mid_rst_cpu_hold",   32'(cpu_hold),       32'(1));
        check("mid_rst_load_done",  32'(load_done),      32'(0));
        check("mid_rst_err_code",   32'(err_code),       32'(0));
        check("mid_rst_in_ready",   32'(bus.in_ready),   32'(1));
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        run_frame("after_rst", good, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader directly upstream of the 16-bit MIPS core's instruction memory.
- Accepts a framed byte stream over a valid/ready handshake and writes 16-bit instruction words into instruction memory starting at address 0.
- Holds the core in reset until a complete frame has loaded and its checksum matches.
- Frame format: word count N as 2 bytes (high byte first), then N words of 2 bytes each (high byte first), then 1 checksum byte equal to the XOR of every preceding frame byte.

Parameters:
- ADDR_W, 13: instruction-memory address width. Matches the core PC width.
- MAX_WORDS, 8192: largest legal N.
- TIMEOUT, 1024: idle cycles allowed between bytes once a frame has started. 0 disables the timeout.

Ports:
- clk, input, 1: single clock.
- rst, input, 1: asynchronous, active-low reset.
- start, input, 1: restarts a load. Honoured only in DONE or ERROR.
- in_valid, input, 1: a byte is offered on in_data.
- in_data, input, 8: stream byte.
- in_ready, output, 1: loader can accept a byte.
- imem_we, output, 1: one-cycle write strobe to instruction memory.
- imem_addr, output, ADDR_W: write address.
- imem_wdata, output, 16: instruction word to write.
- cpu_hold, output, 1: 1 holds the core in reset.
- load_done, output, 1: frame loaded and checksum good.
- load_err, output, 1: frame failed.
- err_code, output, 2: 0 none, 1 checksum, 2 length, 3 timeout.

Behaviour:
- Reset values (rst=0, asynchronous):
  - state=HDR_HI
  - imem_we=0, imem_addr=0, imem_wdata=0
  - cpu_hold=1, load_done=0, load_err=0, err_code=0
  - checksum accumulator=0, word counter=0, idle counter=0
- Handshake:
  - in_ready is decoded from state: 1 in HDR_HI, HDR_LO, DATA_HI, DATA_LO, CHECK; 0 in DONE and ERROR.
  - A byte is accepted on a rising edge with in_valid=1 and in_ready=1.
  - Every accepted byte except the checksum byte is XORed into the accumulator.
- State transitions, each taken on an accepted byte:
  - HDR_HI: latch N[15:8], go to HDR_LO.
  - HDR_LO: latch N[7:0].
    - If N > MAX_WORDS: go to ERROR, err_code=2.
    - Else if N=0: go to CHECK.
    - Else: go to DATA_HI.
  - DATA_HI: latch word[15:8], go to DATA_LO.
  - DATA_LO:
    - On the next cycle: imem_we=1 for exactly one cycle, imem_wdata={hi,lo}, imem_addr=current word index.
    - Then increment the word index.
    - If the index just written equals N-1, go to CHECK; otherwise go to DATA_HI.
  - CHECK:
    - If the byte equals the accumulator: go to DONE, load_done=1, cpu_hold=0.
    - Otherwise: go to ERROR, err_code=3'd1, cpu_hold stays 1.
- Write latency: one cycle from acceptance of the low byte to imem_we. Back-to-back writes are therefore at most one per two accepted bytes.
- Timeout:
  - The idle counter clears on every accepted byte and whenever state is HDR_HI, DONE or ERROR.
  - It increments on every other cycle.
  - When it reaches TIMEOUT (TIMEOUT≠0): go to ERROR, err_code=3.
  - The timeout takes priority over a byte accepted in the same cycle. That byte is discarded and no write occurs.
- DONE/ERROR:
  - in_ready=0 and all outputs are held.
  - start=1 returns to HDR_HI, clears load_done, load_err, err_code, the accumulator and the counters, and sets cpu_hold=1. Memory contents are not cleared.
  - start is ignored in all other states.
- Reset asserted mid-frame aborts immediately. A partial image may remain in memory, and cpu_hold=1 after reset.
- The word index wraps never: a length violation is caught at the header. With N=MAX_WORDS the last address written is MAX_WORDS-1.

Decomposition:
- Shared package mips16_pkg holds:
  - INST_SIZE=16
  - the loader state enum (HDR_HI, HDR_LO, DATA_HI, DATA_LO, CHECK, DONE, ERROR)
  - error-code constants ERR_NONE, ERR_CSUM, ERR_LEN, ERR_TIMEOUT
- One sub-module, idle_timer: a parameterised counter with clear, enable and an expired flag. It is used for the timeout.
- The FSM, accumulator and write path stay in imem_loader.

Test Plan:
- Frame 00 02 12 34 AB CD, checksum 00^02^12^34^AB^CD=0x42, sent continuously:
  - writes mem[0]=0x1234 and mem[1]=0xABCD, one imem_we pulse each.
  - load_done=1, cpu_hold=0, err_code=0.
- Same frame with checksum 0x43 -> no change to writes; load_err=1, err_code=1, cpu_hold=1.
- Header 20 01 (N=8193) with MAX_WORDS=8192 -> ERROR on the header low byte, zero writes, err_code=2.
- Frame 00 00 00 -> no writes, load_done=1.
- TIMEOUT=16; send 00 01 12, then hold in_valid=0 for 16 cycles -> ERROR with err_code=3, no write.
  - Then pulse start and send a good frame -> DONE.
- Random in_valid gaps of 0-5 cycles on the first frame -> same memory image and status as the continuous case.
- Assert rst during DATA_LO -> outputs return to reset values immediately.
